countdown_timer: RTL and testbench

- Loadable down-counter timer, the counterpart to the team's 4-bit enable/reset up-counter.
- Counts a preset value down to zero at a prescaled rate derived from CLOCK_50.
- Supports start, pause and resume, and raises a one-cycle done pulse when the count reaches zero.
- Instantiated under top; switches and keys supply load/start/pause, and LEDR/HEX0 show q and status.

---
 rtl/countdown_timer.sv | 175 +++++++++++++++++
 tb/tb_countdown_timer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
//------------------------------------------------------------------------------
// countdown_timer
//
// Loadable down-counter. A preset value is loaded into q and, once started,
// q counts down by one every TICK_DIV clock cycles until it reaches zero.
// Counting can be paused and resumed. A one-cycle done pulse marks the first
// cycle in which q reads zero after counting down.
//
// Parameters
//   WIDTH     width of the count value q
//   TICK_DIV  clock cycles per decrement while running (>= 1)
//
// Ports
//   clock       system clock; everything happens on the rising edge
//   resetp      synchronous active-high reset
//   load        load load_value into q (wins over everything except resetp)
//   load_value  preset count
//   start       level-sampled start / resume request
//   pause       level-sampled pause request
//   q           current count (registered)
//   tick        one-cycle pulse in the cycle q shows a freshly decremented value
//   running     high while the state machine is in RUN
//   done        one-cycle pulse in the first cycle q == 0 after counting down
//   hex         active-low seven-segment pattern (gfedcba) of q[3:0]
//   fsm_state   current state encoding for observation (IDLE=0, RUN=1,
//               PAUSE=2, DONE=3)
//
// Handshake note: start, pause and load are plain levels sampled on every
// rising edge; there is no valid/ready pairing on this block.
//------------------------------------------------------------------------------
module countdown_timer #(
   parameter int WIDTH    = 4,
   parameter int TICK_DIV = 50000000
) (
   input  logic             clock,
   input  logic             resetp,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             pause,
   output logic [WIDTH-1:0] q,
   output logic             tick,
   output logic             running,
   output logic             done,
   output logic [6:0]       hex,
   output logic [1:0]       fsm_state
);

   // Prescaler needs at least one bit even when TICK_DIV == 1.
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic          wrap;

   // The prescaler only wraps while running; with TICK_DIV == 1 it sits at
   // zero, so every RUN cycle is a wrap.
   assign wrap = (presc == PRESC_LAST);

   always_ff @(posedge clock) begin
      if (resetp) begin
         state <= IDLE;
         q     <= '0;
         presc <= '0;
         tick  <= 1'b0;
         done  <= 1'b0;
      end else if (load) begin
         // Load overrides any state and any start/pause in the same cycle.
         state <= IDLE;
         q     <= load_value;
         presc <= '0;
         tick  <= 1'b0;
         done  <= 1'b0;
      end else begin
         // Pulses default low so they can never last more than one cycle.
         tick <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               // A start with nothing to count is ignored.
               if (start && (q != '0)) begin
                  state <= RUN;
                  presc <= '0;
               end
            end

            RUN: begin
               if (wrap) begin
                  presc <= '0;
                  tick  <= 1'b1;
                  if (q <= WIDTH'(1)) begin
                     // Reaching zero beats a simultaneous pause.
                     q     <= '0;
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     q <= q - WIDTH'(1);
                     if (pause) begin
                        state <= PAUSE;
                     end
                  end
               end else if (pause) begin
                  // Prescaler is held, not advanced, on the pausing edge so
                  // resume continues exactly where counting left off.
                  state <= PAUSE;
               end else begin
                  presc <= presc + PW'(1);
               end
            end

            PAUSE: begin
               // start together with pause keeps the timer paused.
               if (start && !pause) begin
                  state <= RUN;
               end
            end

            DONE: begin
               // Only load or resetp leaves DONE.
               state <= DONE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign running   = (state == RUN);
   assign fsm_state = state;

   // Display nibble: low four bits of q, zero-padded for narrow counters.
   logic [3:0] nib;
   generate
      if (WIDTH >= 4) begin : g_nib_slice
         assign nib = q[3:0];
      end else begin : g_nib_pad
         assign nib = {{(4 - WIDTH){1'b0}}, q};
      end
   endgenerate

   // Active-low segments, bit order gfedcba.
   always_comb begin
      hex = 7'b1111111;
      case (nib)
         4'h0: hex = 7'b1000000;
         4'h1: hex = 7'b1111001;
         4'h2: hex = 7'b0100100;
         4'h3: hex = 7'b0110000;
         4'h4: hex = 7'b0011001;
         4'h5: hex = 7'b0010010;
         4'h6: hex = 7'b0000010;
         4'h7: hex = 7'b1111000;
         4'h8: hex = 7'b0000000;
         4'h9: hex = 7'b0010000;
         4'hA: hex = 7'b0001000;
         4'hB: hex = 7'b0000011;
         4'hC: hex = 7'b1000110;
         4'hD: hex = 7'b0100001;
         4'hE: hex = 7'b0000110;
         4'hF: hex = 7'b0001110;
         default: hex = 7'b1111111;
      endcase
   end

endmodule

// File: tb/tb_countdown_timer.sv
//------------------------------------------------------------------------------
// tb_countdown_timer
//
// Directed bench for countdown_timer. Two instances share the clock and
// reset: dut4 with TICK_DIV=4 and dut1 with TICK_DIV=1, both WIDTH=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each sample reflects the edge just taken.
//------------------------------------------------------------------------------
module tb_countdown_timer;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // clock / reset
   logic clock = 1'b0;
   logic resetp;
   always #5 clock = ~clock;

   // dut4 signals
   logic       load4, start4, pause4;
   logic [3:0] lv4;
   logic [3:0] q4;
   logic       tick4, running4, done4;
   logic [6:0] hex4;
   logic [1:0] st4;

   // dut1 signals
   logic       load1, start1, pause1;
   logic [3:0] lv1;
   logic [3:0] q1;
   logic       tick1, running1, done1;
   logic [6:0] hex1;
   logic [1:0] st1;

   countdown_timer #(.WIDTH(4), .TICK_DIV(4)) dut4 (
      .clock      (clock),
      .resetp     (resetp),
      .load       (load4),
      .load_value (lv4),
      .start      (start4),
      .pause      (pause4),
      .q          (q4),
      .tick       (tick4),
      .running    (running4),
      .done       (done4),
      .hex        (hex4),
      .fsm_state  (st4)
   );

   countdown_timer #(.WIDTH(4), .TICK_DIV(1)) dut1 (
      .clock      (clock),
      .resetp     (resetp),
      .load       (load1),
      .load_value (lv1),
      .start      (start1),
      .pause      (pause1),
      .q          (q1),
      .tick       (tick1),
      .running    (running1),
      .done       (done1),
      .hex        (hex1),
      .fsm_state  (st1)
   );

   // scoreboard counters
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Reference seven-segment patterns (active low, gfedcba).
   function automatic logic [6:0] seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;  default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   task automatic load_dut4(input logic [3:0] v);
      lv4   = v;
      load4 = 1'b1;
      step();
      load4 = 1'b0;
   endtask

   task automatic start_dut4();
      start4 = 1'b1;
      step();
      start4 = 1'b0;
   endtask

   int exp_q;
   int ticks_seen;

   initial begin
      resetp = 1'b1;
      load4 = 0; start4 = 0; pause4 = 0; lv4 = 0;
      load1 = 0; start1 = 0; pause1 = 0; lv1 = 0;
      step();
      step();

      // Reset values
      check("rst_q",       32'(q4), 32'd0);
      check("rst_state",   32'(st4), 32'(S_IDLE));
      check("rst_running", 32'(running4), 32'd0);
      check("rst_tick",    32'(tick4), 32'd0);
      check("rst_done",    32'(done4), 32'd0);
      check("rst_hex",     32'(hex4), 32'(7'b1000000));
      check("rst_q_d1",    32'(q1), 32'd0);
      resetp = 1'b0;

      // 1. Reset while running with q=5 and prescaler at 2
      load_dut4(4'd5);
      start_dut4();
      step();
      step();
      check("t1_running_pre", 32'(running4), 32'd1);
      check("t1_q_pre",       32'(q4), 32'd5);
      resetp = 1'b1;
      step();
      resetp = 1'b0;
      check("t1_q",       32'(q4), 32'd0);
      check("t1_state",   32'(st4), 32'(S_IDLE));
      check("t1_running", 32'(running4), 32'd0);
      check("t1_done",    32'(done4), 32'd0);
      check("t1_hex",     32'(hex4), 32'(7'b1000000));

      // 2. Load 3, start: decrements at k+4, k+8, k+12; done after k+12
      load_dut4(4'd3);
      check("t2_q_load", 32'(q4), 32'd3);
      start_dut4();
      check("t2_running", 32'(running4), 32'd1);
      check("t2_q_k",     32'(q4), 32'd3);
      ticks_seen = 0;
      for (int i = 1; i <= 14; i++) begin
         step();
         exp_q = (i >= 12) ? 0 : 3 - (i / 4);
         check("t2_q",    32'(q4), 32'(exp_q));
         check("t2_tick", 32'(tick4), ((i % 4 == 0) && (i <= 12)) ? 32'd1 : 32'd0);
         check("t2_done", 32'(done4), (i == 12) ? 32'd1 : 32'd0);
         check("t2_state", 32'(st4), (i >= 12) ? 32'(S_DONE) : 32'(S_RUN));
         if (tick4) ticks_seen++;
      end
      check("t2_tick_count", 32'(ticks_seen), 32'd3);
      check("t2_running_end", 32'(running4), 32'd0);

      // 3. Load 5, start, pause after 6 cycles, hold 10, resume
      load_dut4(4'd5);
      start_dut4();
      for (int i = 1; i <= 6; i++) step();
      check("t3_q_before_pause", 32'(q4), 32'd4);
      pause4 = 1'b1;
      step();
      check("t3_state_pause", 32'(st4), 32'(S_PAUSE));
      for (int i = 1; i <= 10; i++) begin
         step();
         check("t3_q_hold", 32'(q4), 32'd4);
         check("t3_tick_hold", 32'(tick4), 32'd0);
      end
      check("t3_state_held", 32'(st4), 32'(S_PAUSE));
      // start and pause together: remains paused
      start4 = 1'b1;
      step();
      check("t3_both_stay", 32'(st4), 32'(S_PAUSE));
      pause4 = 1'b0;
      step();
      start4 = 1'b0;
      check("t3_resume", 32'(st4), 32'(S_RUN));
      step();
      check("t3_q_r1",    32'(q4), 32'd4);
      check("t3_tick_r1", 32'(tick4), 32'd0);
      step();
      check("t3_q_r2",    32'(q4), 32'd3);
      check("t3_tick_r2", 32'(tick4), 32'd1);

      // 4. Pause on the wrap edge with q=1: DONE wins
      load_dut4(4'd1);
      start_dut4();
      step();
      step();
      step();
      check("t4_q_pre", 32'(q4), 32'd1);
      pause4 = 1'b1;
      step();
      pause4 = 1'b0;
      check("t4_q",     32'(q4), 32'd0);
      check("t4_state", 32'(st4), 32'(S_DONE));
      check("t4_done",  32'(done4), 32'd1);
      check("t4_tick",  32'(tick4), 32'd1);
      start_dut4();
      check("t4_start_q",     32'(q4), 32'd0);
      check("t4_start_state", 32'(st4), 32'(S_DONE));
      check("t4_start_run",   32'(running4), 32'd0);
      check("t4_done_once",   32'(done4), 32'd0);

      // 5. Load 0 then start: ignored
      load_dut4(4'd0);
      start4 = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         check("t5_state", 32'(st4), 32'(S_IDLE));
         check("t5_running", 32'(running4), 32'd0);
         check("t5_done", 32'(done4), 32'd0);
      end
      start4 = 1'b0;
      // Load 9 with start asserted while counting: load wins
      load_dut4(4'd9);
      start_dut4();
      step();
      step();
      lv4 = 4'd9;
      load4 = 1'b1;
      start4 = 1'b1;
      step();
      load4 = 1'b0;
      start4 = 1'b0;
      check("t5_load_q",     32'(q4), 32'd9);
      check("t5_load_state", 32'(st4), 32'(S_IDLE));
      check("t5_load_run",   32'(running4), 32'd0);
      start_dut4();
      for (int i = 1; i <= 3; i++) step();
      check("t5_q_k3", 32'(q4), 32'd9);
      step();
      check("t5_q_k4", 32'(q4), 32'd8);

      // 6. TICK_DIV=1 instance: load 15, one decrement per cycle
      lv1 = 4'd15;
      load1 = 1'b1;
      step();
      load1 = 1'b0;
      check("t6_hex_f", 32'(hex1), 32'(7'b0001110));
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      check("t6_q_k", 32'(q1), 32'd15);
      for (int i = 1; i <= 16; i++) begin
         step();
         exp_q = (i >= 15) ? 0 : 15 - i;
         check("t6_q",    32'(q1), 32'(exp_q));
         check("t6_hex",  32'(hex1), 32'(seg(4'(exp_q))));
         check("t6_tick", 32'(tick1), (i <= 15) ? 32'd1 : 32'd0);
         check("t6_done", 32'(done1), (i == 15) ? 32'd1 : 32'd0);
      end
      check("t6_state", 32'(st1), 32'(S_DONE));
      check("t6_hex_0", 32'(hex1), 32'(7'b1000000));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
